// File: rtl/tdm_rx_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module : tdm_rx_ctrl
// Sequencer and channel unloader for the 8 x 32-bit TDM deserializer.
// Rev    : 1.0
// ============================================================================
module tdm_rx_ctrl #(
   parameter int TIMEOUT     = 4096,
   parameter int RESTART_CYC = 16,
   parameter int LOCK_FRAMES = 2,
   parameter int CNT_W       = 8
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic             run,
   input  logic [7:0]       cfg_patt,
   input  logic [7:0]       cfg_mask,
   output logic             des_enable,
   output logic [7:0]       des_patt,
   output logic [7:0]       des_mask,
   input  logic             des_valid,
   input  logic [255:0]     des_pdata,
   output logic             ch_valid,
   input  logic             ch_ready,
   output logic [2:0]       ch_idx,
   output logic [31:0]      ch_data,
   output logic             ch_last,
   output logic             locked,
   output logic             lost,
   output logic [CNT_W-1:0] overrun_cnt
);

   localparam int TMR_MAX = (TIMEOUT > RESTART_CYC) ? TIMEOUT : RESTART_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX);
   localparam int FCNT_W  = $clog2(LOCK_FRAMES + 1);

   localparam logic [TMR_W-1:0]  TMO_LAST = TMR_W'(TIMEOUT - 1);
   localparam logic [TMR_W-1:0]  RST_LAST = TMR_W'(RESTART_CYC - 1);
   localparam logic [FCNT_W-1:0] LOCK_N   = FCNT_W'(LOCK_FRAMES);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARM     = 2'd1,
      S_LOCKED  = 2'd2,
      S_RECOVER = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [TMR_W-1:0]   tmr_q, tmr_d;
   logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
   logic [7:0]         patt_q, patt_d;
   logic [7:0]         mask_q, mask_d;
   logic               lost_q, lost_d;
   logic [255:0]       buf_q, buf_d;
   logic               vld_q, vld_d;
   logic [2:0]         idx_q, idx_d;
   logic [CNT_W-1:0]   ovr_q, ovr_d;

   logic               w_active;
   logic               w_timeout;
   logic               w_beat;
   logic               w_free;
   logic [FCNT_W-1:0]  w_fcnt_inc;
   logic [2:0]         w_sel;

   assign w_active   = (state_q == S_ARM) || (state_q == S_LOCKED);
   assign w_timeout  = w_active && !des_valid && (tmr_q == TMO_LAST);
   assign w_beat     = vld_q && ch_ready;
   // A frame can land either into an empty buffer or on the final beat of the current one.
   assign w_free     = !vld_q || (w_beat && (idx_q == 3'd7));
   assign w_fcnt_inc = fcnt_q + 1'b1;

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q + 1'b1;
      fcnt_d  = fcnt_q;
      patt_d  = patt_q;
      mask_d  = mask_q;
      lost_d  = 1'b0;
      buf_d   = buf_q;
      vld_d   = vld_q;
      idx_d   = idx_q;
      ovr_d   = ovr_q;

      if (w_beat) begin
         idx_d = idx_q + 3'd1;
         if (idx_q == 3'd7) begin
            vld_d = 1'b0;
         end
      end

      if ((state_q == S_LOCKED) && des_valid) begin
         if (w_free) begin
            buf_d = des_pdata;
            vld_d = 1'b1;
            idx_d = 3'd0;
         end else if (ovr_q != {CNT_W{1'b1}}) begin
            ovr_d = ovr_q + 1'b1;
         end
      end

      if (w_active && des_valid) begin
         tmr_d = '0;
      end

      case (state_q)
         S_IDLE: begin
            tmr_d = '0;
            if (run) begin
               patt_d  = cfg_patt;
               mask_d  = cfg_mask;
               fcnt_d  = '0;
               state_d = S_ARM;
            end
         end
         S_ARM: begin
            if (des_valid) begin
               fcnt_d = w_fcnt_inc;
               if (w_fcnt_inc == LOCK_N) begin
                  state_d = S_LOCKED;
                  tmr_d   = '0;
               end
            end else if (w_timeout) begin
               state_d = S_RECOVER;
               tmr_d   = '0;
            end
         end
         S_LOCKED: begin
            if (w_timeout) begin
               state_d = S_RECOVER;
               tmr_d   = '0;
               lost_d  = 1'b1;
            end
         end
         S_RECOVER: begin
            if (tmr_q == RST_LAST) begin
               state_d = S_ARM;
               fcnt_d  = '0;
               tmr_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            tmr_d   = '0;
         end
      endcase

      // Stopping overrides everything except the overrun history.
      if (!run) begin
         state_d = S_IDLE;
         tmr_d   = '0;
         lost_d  = 1'b0;
         buf_d   = buf_q;
         vld_d   = 1'b0;
         idx_d   = 3'd0;
         ovr_d   = ovr_q;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= S_IDLE;
         tmr_q   <= '0;
         fcnt_q  <= '0;
         patt_q  <= '0;
         mask_q  <= '0;
         lost_q  <= 1'b0;
         buf_q   <= '0;
         vld_q   <= 1'b0;
         idx_q   <= '0;
         ovr_q   <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         fcnt_q  <= fcnt_d;
         patt_q  <= patt_d;
         mask_q  <= mask_d;
         lost_q  <= lost_d;
         buf_q   <= buf_d;
         vld_q   <= vld_d;
         idx_q   <= idx_d;
         ovr_q   <= ovr_d;
      end
   end

   // CH1 occupies the top word of the frame.
   assign w_sel       = 3'd7 - idx_q;
   assign ch_data     = buf_q[{w_sel, 5'd0} +: 32];
   assign ch_valid    = vld_q;
   assign ch_idx      = idx_q;
   assign ch_last     = vld_q && (idx_q == 3'd7);
   assign des_enable  = w_active;
   assign des_patt    = patt_q;
   assign des_mask    = mask_q;
   assign locked      = (state_q == S_LOCKED);
   assign lost        = lost_q;
   assign overrun_cnt = ovr_q;

endmodule
`default_nettype wire
